musa_trace_tx: RTL

Hardware commit-trace transmitter for the MUSA core. It captures one record per retired instruction from the control path: instruction word, pc_src, mem_read, mem_write, push, pop, reg_write and alu_op. Records are buffered in a small FIFO and streamed out as fixed 7-byte frames over a byte-wide valid/ready link. It sits beside dataPath and produces the same event stream that the simulation monitor samples, so silicon and FPGA runs can be traced off-chip.

---
 rtl/musa_trace_pkg.sv | 47 ++++
 rtl/musa_trace_fifo.sv | 64 ++++++
 rtl/musa_trace_tx.sv | 135 +++++++++++++
 3 files changed

// File: rtl/musa_trace_pkg.sv
// MUSA commit-trace shared types: record layout, FSM states
// and the frame byte mux used by the transmitter.
package musa_trace_pkg;

  localparam logic [7:0] SYNC_BYTE = 8'hA5;
  localparam int FRAME_LEN = 7;

  typedef struct packed {
    logic [31:0] instr;
    logic        pc_src;
    logic        mem_read;
    logic        mem_write;
    logic        push;
    logic        pop;
    logic        reg_write;
    logic [3:0]  alu_op;
    logic [3:0]  seq;
    logic        lost;
  } trace_rec_t;

  typedef enum logic {
    IDLE,
    SEND
  } tx_state_t;

  function automatic logic [7:0] frame_byte(
    input trace_rec_t r,
    input logic [2:0] i
  );
    logic [7:0] b;
    b = 8'h00;
    case (i)
      3'd0: b = SYNC_BYTE;
      3'd1: b = {r.reg_write, r.pop, r.push,
                 r.mem_write, r.mem_read,
                 r.pc_src, r.lost, 1'b0};
      3'd2: b = {r.seq, r.alu_op};
      3'd3: b = r.instr[31:24];
      3'd4: b = r.instr[23:16];
      3'd5: b = r.instr[15:8];
      3'd6: b = r.instr[7:0];
      default: b = 8'h00;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/musa_trace_fifo.sv
// Synchronous record FIFO. Ports: wr_en/wr_data, rd_en/rd_data
// (head shown combinationally), full, empty, count.
module musa_trace_fifo
  import musa_trace_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  trace_rec_t    wr_data,
  input  logic          rd_en,
  output trace_rec_t    rd_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  trace_rec_t    mem_q [DEPTH];
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_wr, do_rd;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = mem_q[rptr_q];

  // full comes from the registered count, so a pop in
  // the same cycle never frees room for a write
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (do_wr) wptr_d = wptr_q + 1'b1;
    if (do_rd) rptr_d = rptr_q + 1'b1;
    unique case ({do_wr, do_rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
      if (do_wr) mem_q[wptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/musa_trace_tx.sv
// Commit-trace transmitter: captures retired-instruction records,
// queues them, streams 7-byte A5 frames on a valid/ready byte link.
module musa_trace_tx
  import musa_trace_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ALU_OP_W   = 4,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  trace_en,
  input  logic                  commit_valid,
  input  logic [DATA_WIDTH-1:0] commit_instr,
  input  logic                  commit_pc_src,
  input  logic                  commit_mem_read,
  input  logic                  commit_mem_write,
  input  logic                  commit_push,
  input  logic                  commit_pop,
  input  logic                  commit_reg_write,
  input  logic [ALU_OP_W-1:0]   commit_alu_op,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [7:0]            drop_count
);

  localparam int CW = $clog2(DEPTH) + 1;

  tx_state_t     state_q, state_d;
  logic [2:0]    idx_q, idx_d;
  trace_rec_t    frame_q, frame_d;
  logic [3:0]    seq_q, seq_d;
  logic          lost_q, lost_d;
  logic [7:0]    drop_q, drop_d;

  trace_rec_t    wr_rec, head;
  logic          fifo_full, fifo_empty, fifo_rd;
  logic          cap, wr, drop;
  logic [CW-1:0] fifo_level_unused;

  assign cap  = trace_en && commit_valid;
  assign wr   = cap && !fifo_full;
  assign drop = cap && fifo_full;

  always_comb begin
    wr_rec           = '0;
    wr_rec.instr     = commit_instr;
    wr_rec.pc_src    = commit_pc_src;
    wr_rec.mem_read  = commit_mem_read;
    wr_rec.mem_write = commit_mem_write;
    wr_rec.push      = commit_push;
    wr_rec.pop       = commit_pop;
    wr_rec.reg_write = commit_reg_write;
    wr_rec.alu_op    = 4'(commit_alu_op);
    wr_rec.seq       = seq_q;
    wr_rec.lost      = lost_q;
  end

  musa_trace_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr),
    .wr_data (wr_rec),
    .rd_en   (fifo_rd),
    .rd_data (head),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_level_unused)
  );

  always_comb begin
    seq_d  = wr ? seq_q + 4'd1 : seq_q;
    lost_d = lost_q;
    if (wr)        lost_d = 1'b0;
    else if (drop) lost_d = 1'b1;
    drop_d = drop_q;
    if (drop && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    frame_d = frame_q;
    fifo_rd = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_rd = 1'b1;
          frame_d = head;
          idx_d   = 3'd0;
          state_d = SEND;
        end
      end
      SEND: begin
        if (tx_ready) begin
          if (idx_q != 3'(FRAME_LEN - 1)) begin
            idx_d = idx_q + 3'd1;
          end else if (!fifo_empty) begin
            // chain the next frame with no idle gap
            fifo_rd = 1'b1;
            frame_d = head;
            idx_d   = 3'd0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx_valid   = (state_q == SEND);
  assign tx_data    = tx_valid ? frame_byte(frame_q, idx_q) : 8'h00;
  assign drop_count = drop_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      frame_q <= '0;
      seq_q   <= '0;
      lost_q  <= 1'b0;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      frame_q <= frame_d;
      seq_q   <= seq_d;
      lost_q  <= lost_d;
      drop_q  <= drop_d;
    end
  end

endmodule
